// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: ALU opcodes, the decoded-control bundle and
// the all-zero bubble that the ID/EX register loads on a squash or stall.
package cpu_pipe_pkg;

    localparam int ALUOP_W = 4;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_SLL = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_SRL = 4'd7;
    localparam logic [ALUOP_W-1:0] ALU_SRA = 4'd8;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic branch;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/load_use_detector.sv
// Flags an ID instruction that reads the destination of a load currently in
// EX; the load data is not available for forwarding until MEM/WB.
module load_use_detector
    import cpu_pipe_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

    // x0 is never a real producer, so a load targeting it cannot stall anyone.
    assign hazard = id_valid && ex_valid && ex_mem_read &&
                    (ex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && (count != MAX))
            count <= count + ONE;
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use stall generation, bubble insertion on
// flush/stall/invalid ID, and saturating stall/flush event counters.
module id_ex_pipe_reg #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = cpu_pipe_pkg::ALUOP_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic [4:0]         id_rd,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic               id_RegWrite,
    input  logic               id_MemRead,
    input  logic               id_MemWrite,
    input  logic               id_MemtoReg,
    input  logic               id_ALUSrc,
    input  logic               id_Branch,
    input  logic [ALUOP_W-1:0] id_ALUOp,
    input  logic               ex_flush,

    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic [4:0]         ex_rs1,
    output logic [4:0]         ex_rs2,
    output logic [4:0]         ex_rd,
    output logic               ex_RegWrite,
    output logic               ex_MemRead,
    output logic               ex_MemWrite,
    output logic               ex_MemtoReg,
    output logic               ex_ALUSrc,
    output logic               ex_Branch,
    output logic [ALUOP_W-1:0] ex_ALUOp,
    output logic               load_use_stall,
    output logic [CNT_W-1:0]   stall_count,
    output logic [CNT_W-1:0]   flush_count
);

    import cpu_pipe_pkg::*;

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  hazard;
    logic  bubble;

    assign id_ctrl = '{reg_write:  id_RegWrite,
                       mem_read:   id_MemRead,
                       mem_write:  id_MemWrite,
                       mem_to_reg: id_MemtoReg,
                       alu_src:    id_ALUSrc,
                       branch:     id_Branch};

    assign ex_RegWrite = ex_ctrl.reg_write;
    assign ex_MemRead  = ex_ctrl.mem_read;
    assign ex_MemWrite = ex_ctrl.mem_write;
    assign ex_MemtoReg = ex_ctrl.mem_to_reg;
    assign ex_ALUSrc   = ex_ctrl.alu_src;
    assign ex_Branch   = ex_ctrl.branch;

    load_use_detector u_detect (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_rd       (ex_rd),
        .hazard      (hazard)
    );

    // A flushed ID instruction is being discarded anyway, so never stall for it.
    assign load_use_stall = hazard && !ex_flush;

    // Flush, stall and an empty ID slot all load the same zero bubble, so the
    // update priority collapses to reset/bubble/load.
    assign bubble = ex_flush || load_use_stall || !id_valid;

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= REG_X0;
            ex_rs2      <= REG_X0;
            ex_rd       <= REG_X0;
            ex_ctrl     <= BUBBLE;
            ex_ALUOp    <= '0;
        end else begin
            ex_valid    <= 1'b1;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_ctrl     <= id_ctrl;
            ex_ALUOp    <= id_ALUOp;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (load_use_stall),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ex_flush),
        .count (flush_count)
    );

endmodule
